// File: rtl/board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// board_mem_arbiter
//
// Shares one synchronous single-port 81-cell Sudoku board RAM between the VGA
// cell renderer and the game-logic FSM. The renderer always wins the port so
// display fetches are never delayed. Game accesses use a four-phase req/ack
// handshake and are issued in the first cycle the renderer leaves idle.
// Addresses at or above CELLS never reach the RAM and read back as 0.
//
// Optional feature: define BOARD_ARB_STATS_EN to add g_wait_max, the longest
// number of cycles a game request waited in IDLE before issue (saturating).
//
// Ports
//   clk25, reset        25 MHz pixel clock, asynchronous active-high reset
//   r_req/r_addr        renderer single-cycle read request
//   r_valid/r_rdata     renderer read data, one cycle after r_req
//   g_req/g_we/g_addr/g_wdata  game request (level, held until g_ack)
//   g_ack/g_rdata       one-cycle acknowledge with read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM port (1-cycle read latency)
//   g_wait_max          [BOARD_ARB_STATS_EN only] longest game wait in cycles
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module board_mem_arbiter #(
    parameter int CELLS = 81,
    parameter int DW    = 5,
    parameter int AW    = 7
) (
    input  logic          clk25,
    input  logic          reset,
    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    output logic          r_valid,
    output logic [DW-1:0] r_rdata,
    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] g_wdata,
    output logic          g_ack,
    output logic [DW-1:0] g_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef BOARD_ARB_STATS_EN
    ,
    output logic [15:0]   g_wait_max
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_RELEASE
    } state_t;

    state_t r_state;
    logic   r_ack;      // g_ack, registered
    logic   r_gread;    // current ack returns RAM data (in-range read)
    logic   r_rvalid;   // renderer request was issued last cycle
    logic   r_rinr;     // ... and its address was in range

    logic   w_r_inr;
    logic   w_g_inr;
    logic   w_g_issue;

    assign w_r_inr   = (r_addr < AW'(CELLS));
    assign w_g_inr   = (g_addr < AW'(CELLS));
    // Game only issues from IDLE in a cycle the renderer leaves the port free.
    assign w_g_issue = (r_state == ST_IDLE) && g_req && !r_req;

    // Memory port mux. The port is forced idle while reset is held so the RAM
    // sees no access even if a request line is already high.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (r_req) begin
                mem_en   = w_r_inr;
                mem_addr = r_addr;
            end else if (w_g_issue) begin
                mem_en    = w_g_inr;
                mem_we    = g_we && w_g_inr;
                mem_addr  = g_addr;
                mem_wdata = g_wdata;
            end
        end
    end

    // Game handshake FSM plus renderer valid pipeline.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ack    <= 1'b0;
            r_gread  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rinr   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_rvalid <= r_req;
            r_rinr   <= r_req && w_r_inr;
            case (r_state)
                ST_IDLE: begin
                    if (w_g_issue) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_gread <= !g_we && w_g_inr;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_RELEASE;
                    r_ack   <= 1'b0;
                    r_gread <= 1'b0;
                end
                ST_RELEASE: begin
                    // A request still held from the last transaction must not re-issue.
                    if (!g_req) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_gread <= 1'b0;
                end
            endcase
        end
    end

    // RAM data arrives one cycle after issue, aligned with the registered flags.
    assign r_valid = r_rvalid;
    assign r_rdata = r_rinr ? mem_rdata : '0;
    assign g_ack   = r_ack;
    assign g_rdata = r_gread ? mem_rdata : '0;

`ifdef BOARD_ARB_STATS_EN
    logic [15:0] r_wait_cnt;
    logic [15:0] r_wait_max;

    // Counts cycles a game request is blocked in IDLE; folded into the maximum
    // on the issue cycle.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_wait_max <= '0;
        end else if (r_state == ST_IDLE && g_req) begin
            if (r_req) begin
                if (r_wait_cnt != 16'hFFFF) r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                if (r_wait_cnt > r_wait_max) r_wait_max <= r_wait_cnt;
                r_wait_cnt <= '0;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign g_wait_max = r_wait_max;
`endif

endmodule
